// File: rtl/fa_pkg.sv
// Shared types and sizes for the full-adder self-test controller.
package fa_pkg;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned VEC_W       = 3;
  localparam int unsigned ERR_W       = 4;
  localparam int unsigned WCNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fa_bist_state_t;

endpackage : fa_pkg

// File: rtl/fa.sv
// 1-bit full adder; also serves as the golden model inside fa_bist.
module fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule : fa

// File: rtl/fa_bist.sv
// Exhaustive self-test controller for a 1-bit full adder: walks all eight
// input vectors, checks each against a golden fa, and reports the results.
module fa_bist
  import fa_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sum,
  input  logic             carry,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_vec
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("fa_bist: SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [WCNT_W-1:0] WCNT_RELOAD = WCNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0]  LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

  fa_bist_state_t    state_q, state_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [ERR_W-1:0]  err_cnt_d;
  logic              fail_valid_d;
  logic [VEC_W-1:0]  fail_vec_d;
  logic [VEC_W-1:0]  abc_d;
  logic              busy_d;
  logic              done_d;
  logic              gold_sum;
  logic              gold_carry;
  logic              mismatch;

  // Golden reference driven from the internal vector register.
  fa u_gold (
    .a     (vec_q[2]),
    .b     (vec_q[1]),
    .c     (vec_q[0]),
    .sum   (gold_sum),
    .carry (gold_carry)
  );

  assign mismatch = (sum != gold_sum) || (carry != gold_carry);
  assign pass     = done && (err_cnt == '0);

  // Next-state, counters and next registered outputs.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    wcnt_d       = wcnt_q;
    err_cnt_d    = err_cnt;
    fail_valid_d = fail_valid;
    fail_vec_d   = fail_vec;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          vec_d        = '0;
          wcnt_d       = WCNT_RELOAD;
          err_cnt_d    = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
        end
      end
      RUN: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end else begin
          if (mismatch) begin
            err_cnt_d = err_cnt + ERR_W'(1);
            if (!fail_valid) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = vec_q;
            end
          end
          // Completion wins over increment so vec never wraps in a run.
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
          end else begin
            vec_d  = vec_q + VEC_W'(1);
            wcnt_d = WCNT_RELOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    abc_d  = (state_d == RUN) ? vec_d : '0;
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      wcnt_q     <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      c          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      wcnt_q     <= wcnt_d;
      err_cnt    <= err_cnt_d;
      fail_valid <= fail_valid_d;
      fail_vec   <= fail_vec_d;
      {a, b, c}  <= abc_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule : fa_bist
